// File: rtl/regex_multi_core_ctrl_pkg.sv
// Shared command codes and core state encoding for the multi-core regex controller.
package regex_multi_core_ctrl_pkg;

  localparam int CMD_W = 4;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP          = 4'd0,
    CMD_RESET        = 4'd1,
    CMD_WRITE        = 4'd2,
    CMD_READ         = 4'd3,
    CMD_START        = 4'd4,
    CMD_RESTART      = 4'd5,
    CMD_READ_ELAPSED = 4'd6
  } cmd_t;

  typedef enum logic [2:0] {
    CS_IDLE     = 3'd0,
    CS_STARTING = 3'd1,
    CS_RUNNING  = 3'd2,
    CS_ACCEPTED = 3'd3,
    CS_REJECTED = 3'd4,
    CS_ERROR    = 3'd5
  } core_state_t;

  function automatic logic is_terminal(input core_state_t s);
    return (s == CS_ACCEPTED) || (s == CS_REJECTED) || (s == CS_ERROR);
  endfunction

  function automatic logic is_active(input core_state_t s);
    return (s == CS_STARTING) || (s == CS_RUNNING);
  endfunction

endpackage

// File: rtl/regex_multi_core_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant searched from a rotating pointer.
// Pointer advances to the slot after the winner; clr returns it to slot 0.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic [N-1:0] req,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;

  always_comb begin
    int   idx;
    logic found;
    grant = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        ptr_d      = (idx == N - 1) ? '0 : PW'(idx + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      ptr_q <= '0;
    else if (clr) ptr_q <= '0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regex_multi_core_ctrl.sv
// Host command front end for CORE_N regex cores sharing one BRAM; read results appear the cycle after the command.
// No host backpressure: commands are one-cycle strobes, illegal ones are dropped and flagged in cmd_error.
module regex_multi_core_ctrl
  import regex_multi_core_ctrl_pkg::*;
#(
  parameter int REG_WIDTH    = 32,
  parameter int CORE_N       = 4,
  parameter int MEM_R_WIDTH  = 64,
  parameter int MEM_R_ADDR_W = 9,
  parameter int MEM_W_WIDTH  = 32,
  parameter int MEM_W_ADDR_W = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  input  logic [REG_WIDTH-1:0]           cmd_register,
  input  logic [REG_WIDTH-1:0]           address_register,
  input  logic [REG_WIDTH-1:0]           data_in_register,
  input  logic [REG_WIDTH-1:0]           core_sel_register,
  output logic [REG_WIDTH-1:0]           status_register,
  output logic [REG_WIDTH-1:0]           data_o_register,
  output logic                           data_o_valid,
  output logic                           irq,
  output logic [MEM_R_ADDR_W-1:0]        bram_r_addr,
  output logic                           bram_r_valid,
  input  logic [MEM_R_WIDTH-1:0]         bram_r_data,
  output logic [MEM_W_ADDR_W-1:0]        bram_w_addr,
  output logic [MEM_W_WIDTH-1:0]         bram_w_data,
  output logic                           bram_w_valid,
  output logic                           core_rst,
  output logic [CORE_N-1:0]              core_start_valid,
  input  logic [CORE_N-1:0]              core_start_ready,
  input  logic [CORE_N-1:0]              core_done,
  input  logic [CORE_N-1:0]              core_accept,
  input  logic [CORE_N-1:0]              core_error,
  input  logic [CORE_N*MEM_R_ADDR_W-1:0] core_mem_addr,
  input  logic [CORE_N-1:0]              core_mem_valid,
  output logic [CORE_N-1:0]              core_mem_ready,
  output logic [MEM_R_WIDTH-1:0]         core_mem_data,
  output logic [CORE_N-1:0]              core_mem_rvalid
);

  localparam int OFF   = $clog2(MEM_R_WIDTH / REG_WIDTH);
  localparam int OFF_W = (OFF > 0) ? OFF : 1;
  localparam int SEL_W = (CORE_N > 1) ? $clog2(CORE_N) : 1;

  core_state_t          st  [CORE_N];
  logic [REG_WIDTH-1:0] cnt [CORE_N];
  logic [CORE_N-1:0]    active;
  logic                 busy;

  cmd_t                 cmd_code;
  logic                 cmd_hi_ok;
  logic                 sel_ok;
  logic [SEL_W-1:0]     sel_idx;
  logic                 cmd_ok;
  logic                 do_soft, do_wr, do_rd, do_el;
  logic [CORE_N-1:0]    start_acc, restart_acc;

  logic                 err_q, soft_q, rd_pend_q, el_vld_q;
  logic [OFF_W-1:0]     slice_q;
  logic [REG_WIDTH-1:0] data_q;
  logic [REG_WIDTH-1:0] rd_slice;
  logic [CORE_N-1:0]    grant;
  logic [CORE_N-1:0]    rv_q;
  logic [MEM_R_ADDR_W-1:0] gnt_addr;

  logic unused_inputs;
  assign unused_inputs = ^{address_register, data_in_register, core_sel_register};

  assign busy      = |active;
  assign cmd_code  = cmd_t'(cmd_register[CMD_W-1:0]);
  assign cmd_hi_ok = (cmd_register[REG_WIDTH-1:CMD_W] == '0);
  assign sel_ok    = (core_sel_register < REG_WIDTH'(CORE_N));
  assign sel_idx   = core_sel_register[SEL_W-1:0];

  always_comb begin
    cmd_ok      = 1'b0;
    do_soft     = 1'b0;
    do_wr       = 1'b0;
    do_rd       = 1'b0;
    do_el       = 1'b0;
    start_acc   = '0;
    restart_acc = '0;
    if (cmd_valid && cmd_hi_ok) begin
      case (cmd_code)
        CMD_NOP:   cmd_ok = 1'b1;
        CMD_RESET: begin cmd_ok = 1'b1; do_soft = 1'b1; end
        CMD_WRITE: if (!busy) begin cmd_ok = 1'b1; do_wr = 1'b1; end
        CMD_READ:  if (!busy) begin cmd_ok = 1'b1; do_rd = 1'b1; end
        CMD_START:
          if (sel_ok && st[sel_idx] == CS_IDLE) begin
            cmd_ok             = 1'b1;
            start_acc[sel_idx] = 1'b1;
          end
        CMD_RESTART:
          if (sel_ok && is_terminal(st[sel_idx])) begin
            cmd_ok               = 1'b1;
            restart_acc[sel_idx] = 1'b1;
          end
        CMD_READ_ELAPSED: if (sel_ok) begin cmd_ok = 1'b1; do_el = 1'b1; end
        default: cmd_ok = 1'b0;
      endcase
    end
  end

  for (genvar i = 0; i < CORE_N; i++) begin : g_core
    core_state_t          st_q, st_d;
    logic [REG_WIDTH-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst)          st_q <= CS_IDLE;
      else if (do_soft) st_q <= CS_IDLE;
      else              st_q <= st_d;
    end

    // error outranks done; accept only qualifies done
    always_comb begin
      st_d = st_q;
      unique case (st_q)
        CS_IDLE:     if (start_acc[i]) st_d = CS_STARTING;
        CS_STARTING: if (core_start_ready[i]) st_d = CS_RUNNING;
        CS_RUNNING:
          if (core_error[i])     st_d = CS_ERROR;
          else if (core_done[i]) st_d = core_accept[i] ? CS_ACCEPTED : CS_REJECTED;
        CS_ACCEPTED, CS_REJECTED, CS_ERROR:
          if (restart_acc[i]) st_d = CS_IDLE;
        default: st_d = CS_IDLE;
      endcase
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                    cnt_q <= '0;
      else if (do_soft || start_acc[i])           cnt_q <= '0;
      else if (st_q == CS_RUNNING && cnt_q != '1) cnt_q <= cnt_q + 1'b1;
    end

    assign st[i]               = st_q;
    assign cnt[i]              = cnt_q;
    assign active[i]           = is_active(st_q);
    assign core_start_valid[i] = (st_q == CS_STARTING);
  end

  always_comb begin
    status_register = '0;
    irq             = 1'b0;
    for (int i = 0; i < CORE_N; i++) begin
      status_register[3*i +: 3] = st[i];
      if (is_terminal(st[i])) irq = 1'b1;
    end
    status_register[REG_WIDTH-1] = busy;
    status_register[REG_WIDTH-2] = err_q;
  end

  rr_arbiter #(.N(CORE_N)) u_arb (
    .clk   (clk),
    .rst   (rst),
    .clr   (do_soft),
    .req   (core_mem_valid & active),
    .grant (grant)
  );

  always_comb begin
    gnt_addr = '0;
    for (int k = 0; k < CORE_N; k++)
      if (grant[k]) gnt_addr = core_mem_addr[k*MEM_R_ADDR_W +: MEM_R_ADDR_W];
  end

  // host reads are refused while any core is active, so the port never has two owners
  assign bram_r_addr    = do_rd ? address_register[OFF +: MEM_R_ADDR_W] : gnt_addr;
  assign bram_r_valid   = do_rd | (|grant);
  assign core_mem_ready = grant;
  assign core_mem_data  = bram_r_data;
  assign core_mem_rvalid = rv_q;

  assign bram_w_valid = do_wr;
  assign bram_w_addr  = do_wr ? address_register[MEM_W_ADDR_W-1:0] : '0;
  assign bram_w_data  = do_wr ? data_in_register[MEM_W_WIDTH-1:0] : '0;

  assign rd_slice        = REG_WIDTH'(bram_r_data >> (REG_WIDTH * int'(slice_q)));
  assign data_o_register = rd_pend_q ? rd_slice : data_q;
  assign data_o_valid    = rd_pend_q | el_vld_q;
  assign core_rst        = rst | soft_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q     <= 1'b0;
      soft_q    <= 1'b0;
      rd_pend_q <= 1'b0;
      el_vld_q  <= 1'b0;
      slice_q   <= '0;
      data_q    <= '0;
      rv_q      <= '0;
    end else begin
      soft_q <= do_soft;
      if (cmd_valid) err_q <= ~cmd_ok;
      if (do_soft) begin
        rd_pend_q <= 1'b0;
        el_vld_q  <= 1'b0;
        slice_q   <= '0;
        data_q    <= '0;
        rv_q      <= '0;
      end else begin
        rd_pend_q <= do_rd;
        el_vld_q  <= do_el;
        rv_q      <= grant;
        if (do_rd) slice_q <= (OFF > 0) ? address_register[OFF_W-1:0] : '0;
        if (do_el)          data_q <= cnt[sel_idx];
        else if (rd_pend_q) data_q <= rd_slice;
      end
    end
  end

endmodule

// File: tb/tb_regex_multi_core_ctrl.sv
// Directed bench: stimulus pushes expected read results and memory returns into queues; a negedge monitor pops and compares.
module tb_regex_multi_core_ctrl;
  import regex_multi_core_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_register, address_register, data_in_register, core_sel_register;
  logic [31:0] status_register, data_o_register;
  logic        data_o_valid, irq;
  logic [8:0]  bram_r_addr;
  logic        bram_r_valid;
  logic [63:0] bram_r_data;
  logic [9:0]  bram_w_addr;
  logic [31:0] bram_w_data;
  logic        bram_w_valid, core_rst;
  logic [3:0]  core_start_valid, core_start_ready, core_done, core_accept, core_error;
  logic [35:0] core_mem_addr;
  logic [3:0]  core_mem_valid, core_mem_ready, core_mem_rvalid;
  logic [63:0] core_mem_data;

  always #5 clk = ~clk;

  regex_multi_core_ctrl dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_register(cmd_register),
    .address_register(address_register), .data_in_register(data_in_register),
    .core_sel_register(core_sel_register), .status_register(status_register),
    .data_o_register(data_o_register), .data_o_valid(data_o_valid), .irq(irq),
    .bram_r_addr(bram_r_addr), .bram_r_valid(bram_r_valid), .bram_r_data(bram_r_data),
    .bram_w_addr(bram_w_addr), .bram_w_data(bram_w_data), .bram_w_valid(bram_w_valid),
    .core_rst(core_rst), .core_start_valid(core_start_valid), .core_start_ready(core_start_ready),
    .core_done(core_done), .core_accept(core_accept), .core_error(core_error),
    .core_mem_addr(core_mem_addr), .core_mem_valid(core_mem_valid), .core_mem_ready(core_mem_ready),
    .core_mem_data(core_mem_data), .core_mem_rvalid(core_mem_rvalid)
  );

  function automatic logic [63:0] winit(input int k);
    return {32'hA5A5_0000 + k, 32'h5A5A_0000 + k};
  endfunction

  // BRAM model: 64-bit words, 32-bit half-word writes, one-cycle read latency
  logic [63:0] mem [512];
  logic        mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int k = 0; k < 512; k++) mem[k] = winit(k);
      mem_init = 1'b1;
    end
    if (bram_w_valid) begin
      if (bram_w_addr[0]) mem[bram_w_addr[9:1]][63:32] = bram_w_data;
      else                mem[bram_w_addr[9:1]][31:0]  = bram_w_data;
    end
    bram_r_data <= mem[bram_r_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0]  rv;
    logic [63:0] d;
  } rv_exp_t;

  logic [31:0] exp_data_q [$];
  rv_exp_t     exp_rv_q   [$];

  always @(negedge clk) begin
    if (!rst) begin
      if (data_o_valid) begin
        chk("data_o_valid expected", {63'd0, data_o_valid}, {63'd0, exp_data_q.size() != 0});
        if (exp_data_q.size() != 0) chk("data_o_register", {32'd0, data_o_register}, {32'd0, exp_data_q.pop_front()});
      end
      if (core_mem_rvalid != 4'd0) begin
        chk("core_mem_rvalid expected", {63'd0, core_mem_rvalid != 4'd0}, {63'd0, exp_rv_q.size() != 0});
        if (exp_rv_q.size() != 0) begin
          rv_exp_t e;
          e = exp_rv_q.pop_front();
          chk("core_mem_rvalid", {60'd0, core_mem_rvalid}, {60'd0, e.rv});
          chk("core_mem_data", core_mem_data, e.d);
        end
      end
    end
  end

  logic       w_vld_s;
  logic [9:0] w_addr_s;
  logic [31:0] w_dat_s;
  logic [8:0] r_addr_s;
  logic [3:0] rdy_s;

  // called at a negedge; returns at the negedge after the command edge
  task automatic do_cmd(input cmd_t code, input logic [31:0] addr, input logic [31:0] data, input logic [31:0] sel);
    cmd_register      = {28'd0, code};
    address_register  = addr;
    data_in_register  = data;
    core_sel_register = sel;
    cmd_valid         = 1'b1;
    #1;
    w_vld_s  = bram_w_valid;
    w_addr_s = bram_w_addr;
    w_dat_s  = bram_w_data;
    r_addr_s = bram_r_addr;
    rdy_s    = core_mem_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  logic [3:0] gseq [3];
  logic [8:0] caddr [4];

  initial begin
    rst = 1'b1; cmd_valid = 1'b0;
    cmd_register = '0; address_register = '0; data_in_register = '0; core_sel_register = '0;
    core_start_ready = '0; core_done = '0; core_accept = '0; core_error = '0;
    core_mem_addr = '0; core_mem_valid = '0;
    repeat (3) @(negedge clk);
    chk("core_rst in reset", {63'd0, core_rst}, 64'd1);
    chk("status in reset", {32'd0, status_register}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("status after reset", {32'd0, status_register}, 64'd0);
    chk("irq after reset", {63'd0, irq}, 64'd0);
    chk("core_rst after reset", {63'd0, core_rst}, 64'd0);
    chk("data_o after reset", {32'd0, data_o_register}, 64'd0);

    // memory write/read
    do_cmd(CMD_WRITE, 32'h10, 32'hDEAD_BEEF, 0);
    chk("write strobe", {63'd0, w_vld_s}, 64'd1);
    chk("write addr", {54'd0, w_addr_s}, 64'h10);
    chk("write data", {32'd0, w_dat_s}, 64'hDEAD_BEEF);
    do_cmd(CMD_WRITE, 32'h11, 32'h0BAD_F00D, 0);
    cmd_register = {28'd0, CMD_START};
    core_sel_register = 0;
    repeat (2) @(negedge clk);
    chk("held cmd without valid", {32'd0, status_register}, 64'd0);
    exp_data_q.push_back(32'h0BAD_F00D);
    do_cmd(CMD_READ, 32'h11, 0, 0);
    chk("read bram addr", {55'd0, r_addr_s}, 64'd8);
    exp_data_q.push_back(32'hDEAD_BEEF);
    do_cmd(CMD_READ, 32'h10, 0, 0);
    @(negedge clk);
    chk("data_o holds", {32'd0, data_o_register}, 64'hDEAD_BEEF);

    // round-robin arbitration over cores 0,1,3
    do_cmd(CMD_START, 0, 0, 0);
    do_cmd(CMD_START, 0, 0, 1);
    do_cmd(CMD_START, 0, 0, 3);
    chk("status three starting", {32'd0, status_register}, 64'h8000_0209);
    caddr[0] = 9'd3; caddr[1] = 9'd5; caddr[2] = 9'd0; caddr[3] = 9'd7;
    core_mem_addr = {caddr[3], caddr[2], caddr[1], caddr[0]};
    gseq[0] = 4'b0001; gseq[1] = 4'b0010; gseq[2] = 4'b1000;
    core_mem_valid = 4'b1011;
    for (int j = 0; j < 6; j++) begin
      int g;
      #1;
      g = (j % 3 == 2) ? 3 : j % 3;
      chk("arb grant", {60'd0, core_mem_ready}, {60'd0, gseq[j % 3]});
      chk("arb bram addr", {55'd0, bram_r_addr}, {55'd0, caddr[g]});
      exp_rv_q.push_back('{rv: gseq[j % 3], d: winit(int'(caddr[g]))});
      @(negedge clk);
    end
    core_mem_valid = 4'b0000;

    // rejected commands leave state alone
    do_cmd(CMD_START, 0, 0, 1);
    chk("start non-idle error", {32'd0, status_register}, 64'hC000_0209);
    do_cmd(CMD_NOP, 0, 0, 0);
    chk("nop clears error", {32'd0, status_register}, 64'h8000_0209);
    do_cmd(CMD_WRITE, 32'h20, 32'h1234_5678, 0);
    chk("write while busy strobe", {63'd0, w_vld_s}, 64'd0);
    chk("write while busy error", {32'd0, status_register}, 64'hC000_0209);
    do_cmd(CMD_NOP, 0, 0, 0);
    do_cmd(CMD_START, 0, 0, 5);
    chk("sel out of range", {32'd0, status_register}, 64'hC000_0209);
    do_cmd(CMD_RESTART, 0, 0, 0);
    chk("restart non-terminal", {32'd0, status_register}, 64'hC000_0209);

    // soft reset with two cores running and a grant in flight
    core_start_ready = 4'b0011;
    @(negedge clk);
    core_start_ready = 4'b0000;
    chk("two running", {32'd0, status_register}, 64'hC000_0212);
    repeat (3) @(negedge clk);
    core_mem_valid = 4'b0011;
    do_cmd(CMD_RESET, 0, 0, 0);
    core_mem_valid = 4'b0000;
    chk("grant in reset cycle", {60'd0, rdy_s}, 64'd1);
    chk("core_rst pulse", {63'd0, core_rst}, 64'd1);
    chk("status after soft reset", {32'd0, status_register}, 64'd0);
    chk("no rvalid after soft reset", {60'd0, core_mem_rvalid}, 64'd0);
    @(negedge clk);
    chk("core_rst one cycle", {63'd0, core_rst}, 64'd0);
    exp_data_q.push_back(32'd0);
    do_cmd(CMD_READ_ELAPSED, 0, 0, 0);
    exp_data_q.push_back(32'd0);
    do_cmd(CMD_READ_ELAPSED, 0, 0, 1);

    // core 2 accepted after 11 running cycles
    do_cmd(CMD_START, 0, 0, 2);
    chk("start_valid core2", {60'd0, core_start_valid}, 64'b0100);
    chk("status core2 starting", {32'd0, status_register}, 64'h8000_0040);
    repeat (2) @(negedge clk);
    core_start_ready = 4'b0100;
    @(negedge clk);
    core_start_ready = 4'b0000;
    chk("status core2 running", {32'd0, status_register}, 64'h8000_0080);
    repeat (10) @(negedge clk);
    core_done = 4'b0100; core_accept = 4'b0100;
    @(negedge clk);
    core_done = 4'b0000; core_accept = 4'b0000;
    chk("status core2 accepted", {32'd0, status_register}, 64'h0000_00C0);
    chk("irq accepted", {63'd0, irq}, 64'd1);
    exp_data_q.push_back(32'd11);
    do_cmd(CMD_READ_ELAPSED, 0, 0, 2);
    do_cmd(CMD_RESTART, 0, 0, 2);
    chk("restart core2", {32'd0, status_register}, 64'd0);
    chk("irq cleared", {63'd0, irq}, 64'd0);
    do_cmd(CMD_RESTART, 0, 0, 2);
    chk("restart idle rejected", {32'd0, status_register}, 64'h4000_0000);

    // simultaneous exit: reject on core 0, error outranks accept on core 1
    do_cmd(CMD_START, 0, 0, 0);
    do_cmd(CMD_START, 0, 0, 1);
    core_start_ready = 4'b0011;
    @(negedge clk);
    core_start_ready = 4'b0000;
    chk("status 0,1 running", {32'd0, status_register}, 64'h8000_0012);
    core_done = 4'b0011; core_accept = 4'b0010; core_error = 4'b0010;
    @(negedge clk);
    core_done = 4'b0000; core_accept = 4'b0000; core_error = 4'b0000;
    chk("status rejected+error", {32'd0, status_register}, 64'h0000_002C);
    chk("irq rejected+error", {63'd0, irq}, 64'd1);
    do_cmd(CMD_RESTART, 0, 0, 0);
    do_cmd(CMD_RESTART, 0, 0, 1);
    chk("status after restarts", {32'd0, status_register}, 64'd0);

    // counter saturation on core 3
    do_cmd(CMD_START, 0, 0, 3);
    core_start_ready = 4'b1000;
    @(negedge clk);
    core_start_ready = 4'b0000;
    chk("status core3 running", {32'd0, status_register}, 64'h8000_0400);
    force dut.g_core[3].cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.g_core[3].cnt_q;
    repeat (3) @(negedge clk);
    exp_data_q.push_back(32'hFFFF_FFFF);
    do_cmd(CMD_READ_ELAPSED, 0, 0, 3);
    core_done = 4'b1000; core_accept = 4'b1000;
    @(negedge clk);
    core_done = 4'b0000; core_accept = 4'b0000;
    chk("status core3 accepted", {32'd0, status_register}, 64'h0000_0600);
    exp_data_q.push_back(32'hFFFF_FFFF);
    do_cmd(CMD_READ_ELAPSED, 0, 0, 3);

    repeat (2) @(negedge clk);
    chk("data queue drained", {32'd0, 32'(exp_data_q.size())}, 64'd0);
    chk("rvalid queue drained", {32'd0, 32'(exp_rv_q.size())}, 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
